dcache_port_arbiter: RTL

//  Shares the single data-cache port between the memory-stage load requester and the
//  LSQ-head store-commit requester. Sequences each access (request, accept, miss wait,

---
 rtl/dcache_port_arbiter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_port_arbiter.sv
// Data-cache port arbiter: serialises memory-stage loads and LSQ-head store commits onto one cache port.
// Optional macro DCACHE_TIMEOUT_EN adds a sticky watchdog on response waits.
module dcache_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LSQ_IDX_W    = 4,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MISS_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 ld_req_valid,
  output logic                 ld_req_ready,
  input  logic [ADDR_W-1:0]    ld_req_addr,
  input  logic [LSQ_IDX_W-1:0] ld_req_id,
  output logic                 ld_done,
  output logic [DATA_W-1:0]    ld_data,
  output logic [LSQ_IDX_W-1:0] ld_done_id,
  output logic                 ld_missed,
  input  logic                 st_req_valid,
  output logic                 st_req_ready,
  input  logic [ADDR_W-1:0]    st_req_addr,
  input  logic [DATA_W-1:0]    st_req_data,
  input  logic [LSQ_IDX_W-1:0] st_req_id,
  output logic                 st_done,
  output logic [LSQ_IDX_W-1:0] st_done_id,
  output logic                 dc_req_valid,
  input  logic                 dc_req_ready,
  output logic                 dc_req_we,
  output logic [ADDR_W-1:0]    dc_req_addr,
  output logic [DATA_W-1:0]    dc_req_wdata,
  input  logic                 dc_resp_valid,
  input  logic [DATA_W-1:0]    dc_resp_data,
  output logic                 dc_timeout
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LD_REQ  = 3'd1;
  localparam logic [2:0] LD_WAIT = 3'd2;
  localparam logic [2:0] ST_REQ  = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  // Degenerate limits would make the starvation or watchdog counters meaningless.
  if (STARVE_LIMIT == 0 || MISS_TIMEOUT < 2) begin : g_bad_params
    $error("dcache_port_arbiter: STARVE_LIMIT must be >= 1 and MISS_TIMEOUT >= 2");
  end

  logic [2:0]           state,        state_n;
  logic [STARVE_W-1:0]  starve_cnt,   starve_cnt_n;
  logic                 drop,         drop_n;
  logic [LSQ_IDX_W-1:0] cur_id,       cur_id_n;
  logic                 dc_req_valid_n;
  logic                 dc_req_we_n;
  logic [ADDR_W-1:0]    dc_req_addr_n;
  logic [DATA_W-1:0]    dc_req_wdata_n;
  logic                 ld_done_n;
  logic [DATA_W-1:0]    ld_data_n;
  logic [LSQ_IDX_W-1:0] ld_done_id_n;
  logic                 ld_missed_n;
  logic                 st_done_n;
  logic [LSQ_IDX_W-1:0] st_done_id_n;
  logic                 store_wins;

`ifdef DCACHE_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(MISS_TIMEOUT);

  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
  logic              dc_timeout_n;
`else
  assign dc_timeout = 1'b0;
`endif

  // A waiting store takes the port when no load competes or loads have used up their quota.
  assign store_wins = st_req_valid &&
                      (!ld_req_valid || (starve_cnt == STARVE_W'(STARVE_LIMIT)));

  // Next-state and registered-output logic.
  always_comb begin
    state_n        = state;
    starve_cnt_n   = starve_cnt;
    drop_n         = drop;
    cur_id_n       = cur_id;
    dc_req_valid_n = dc_req_valid;
    dc_req_we_n    = dc_req_we;
    dc_req_addr_n  = dc_req_addr;
    dc_req_wdata_n = dc_req_wdata;
    ld_done_n      = 1'b0;
    ld_data_n      = ld_data;
    ld_done_id_n   = ld_done_id;
    ld_missed_n    = ld_missed;
    st_done_n      = 1'b0;
    st_done_id_n   = st_done_id;
    ld_req_ready   = 1'b0;
    st_req_ready   = 1'b0;
`ifdef DCACHE_TIMEOUT_EN
    wait_cnt_n     = '0;
    dc_timeout_n   = dc_timeout;
`endif

    case (state)
      IDLE: begin
        if (store_wins) begin
          st_req_ready   = 1'b1;
          state_n        = ST_REQ;
          dc_req_valid_n = 1'b1;
          dc_req_we_n    = 1'b1;
          dc_req_addr_n  = st_req_addr;
          dc_req_wdata_n = st_req_data;
          cur_id_n       = st_req_id;
          starve_cnt_n   = '0;
        end else if (ld_req_valid && !flush) begin
          ld_req_ready   = 1'b1;
          state_n        = LD_REQ;
          dc_req_valid_n = 1'b1;
          dc_req_we_n    = 1'b0;
          dc_req_addr_n  = ld_req_addr;
          dc_req_wdata_n = '0;
          cur_id_n       = ld_req_id;
          drop_n         = 1'b0;
          if (st_req_valid && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
            starve_cnt_n = starve_cnt + STARVE_W'(1);
          end
        end
      end

      LD_REQ: begin
        // A squashed load is withdrawn before the cache ever owes a response.
        if (flush) begin
          state_n        = IDLE;
          dc_req_valid_n = 1'b0;
        end else if (dc_req_ready) begin
          state_n        = LD_WAIT;
          dc_req_valid_n = 1'b0;
          ld_missed_n    = 1'b1;
        end
      end

      LD_WAIT: begin
        // Once accepted, a squashed load still has to swallow its response.
        if (flush) begin
          drop_n      = 1'b1;
          ld_missed_n = 1'b0;
        end
        if (dc_resp_valid) begin
          state_n     = IDLE;
          ld_missed_n = 1'b0;
          drop_n      = 1'b0;
          if (!drop && !flush) begin
            ld_done_n    = 1'b1;
            ld_data_n    = dc_resp_data;
            ld_done_id_n = cur_id;
          end
        end
      end

      ST_REQ: begin
        if (dc_req_ready) begin
          state_n        = ST_WAIT;
          dc_req_valid_n = 1'b0;
        end
      end

      ST_WAIT: begin
        if (dc_resp_valid) begin
          state_n      = IDLE;
          st_done_n    = 1'b1;
          st_done_id_n = cur_id;
        end
      end

      default: begin
        state_n        = IDLE;
        dc_req_valid_n = 1'b0;
        ld_missed_n    = 1'b0;
        drop_n         = 1'b0;
      end
    endcase

`ifdef DCACHE_TIMEOUT_EN
    // Watchdog: a response that never arrives aborts the access without a done pulse.
    if (((state == LD_WAIT) || (state == ST_WAIT)) && !dc_resp_valid) begin
      if (wait_cnt == WAIT_W'(MISS_TIMEOUT - 1)) begin
        state_n      = IDLE;
        dc_timeout_n = 1'b1;
        ld_missed_n  = 1'b0;
        drop_n       = 1'b0;
      end else begin
        wait_cnt_n = wait_cnt + WAIT_W'(1);
      end
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      drop         <= 1'b0;
      cur_id       <= '0;
      dc_req_valid <= 1'b0;
      dc_req_we    <= 1'b0;
      dc_req_addr  <= '0;
      dc_req_wdata <= '0;
      ld_done      <= 1'b0;
      ld_data      <= '0;
      ld_done_id   <= '0;
      ld_missed    <= 1'b0;
      st_done      <= 1'b0;
      st_done_id   <= '0;
    end else begin
      state        <= state_n;
      starve_cnt   <= starve_cnt_n;
      drop         <= drop_n;
      cur_id       <= cur_id_n;
      dc_req_valid <= dc_req_valid_n;
      dc_req_we    <= dc_req_we_n;
      dc_req_addr  <= dc_req_addr_n;
      dc_req_wdata <= dc_req_wdata_n;
      ld_done      <= ld_done_n;
      ld_data      <= ld_data_n;
      ld_done_id   <= ld_done_id_n;
      ld_missed    <= ld_missed_n;
      st_done      <= st_done_n;
      st_done_id   <= st_done_id_n;
    end
  end

`ifdef DCACHE_TIMEOUT_EN
  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt   <= '0;
      dc_timeout <= 1'b0;
    end else begin
      wait_cnt   <= wait_cnt_n;
      dc_timeout <= dc_timeout_n;
    end
  end
`endif

endmodule
